// File: rtl/alu_pkg.sv
// Shared definitions for the ALU loader: opcode values, FSM states and
// the bit positions of the capture-status vector.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    localparam int LD_A  = 0;
    localparam int LD_B  = 1;
    localparam int LD_OP = 2;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub with carry and signed overflow, bitwise logic,
// and shifts. Undefined opcodes give a zero result with the error flag set.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [OP_W-1:0]   i_op,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_ovf,
    output logic              o_err
);

    localparam int SHW = $clog2(DATA_W);
    // Opcode constants are 6 bits; compare at whichever width is wider.
    localparam int OPX = (OP_W > 6) ? OP_W : 6;

    logic [OPX-1:0]  w_op;
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;
    logic [SHW-1:0]  w_shamt;
    logic            w_signA;
    logic            w_signB;

    assign w_op    = OPX'(i_op);
    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
    assign w_shamt = i_b[SHW-1:0];
    assign w_signA = i_a[DATA_W-1];
    assign w_signB = i_b[DATA_W-1];

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        o_ovf    = 1'b0;
        o_err    = 1'b0;
        case (w_op)
            OPX'(OP_ADD): begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
                o_ovf    = (w_signA == w_signB) && (w_sum[DATA_W-1] != w_signA);
            end
            OPX'(OP_SUB): begin
                o_result = w_diff[DATA_W-1:0];
                o_carry  = w_diff[DATA_W];
                o_ovf    = (w_signA != w_signB) && (w_diff[DATA_W-1] != w_signA);
            end
            OPX'(OP_AND): o_result = i_a & i_b;
            OPX'(OP_OR):  o_result = i_a | i_b;
            OPX'(OP_XOR): o_result = i_a ^ i_b;
            OPX'(OP_NOR): o_result = ~(i_a | i_b);
            OPX'(OP_SRA): o_result = DATA_W'($signed(i_a) >>> w_shamt);
            OPX'(OP_SRL): o_result = i_a >> w_shamt;
            default:      o_err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_loader.sv
// Button-driven operand loader: captures A, B and opcode from the switches,
// then runs one ALU operation and presents a registered result with a valid pulse.
module alu_loader
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_switches,
    input  logic              i_btn_A,
    input  logic              i_btn_B,
    input  logic              i_btn_OP,
    output logic [DATA_W-1:0] o_result,
    output logic              o_valid,
    output logic              o_carry,
    output logic              o_zero,
    output logic              o_ovf,
    output logic              o_err,
    output logic [2:0]        o_loaded
);

    state_t            r_state;
    state_t            w_nextState;
    logic              r_prevA;
    logic              r_prevB;
    logic              r_prevOp;
    logic              w_edgeA;
    logic              w_edgeB;
    logic              w_edgeOp;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic [2:0]        r_loaded;
    logic [2:0]        w_loadedNext;
    logic [DATA_W-1:0] r_result;
    logic              r_valid;
    logic              r_carry;
    logic              r_zero;
    logic              r_ovf;
    logic              r_err;
    logic [DATA_W-1:0] w_aluResult;
    logic              w_aluCarry;
    logic              w_aluOvf;
    logic              w_aluErr;

    // Tracking the level during reset too means a button held through reset never fires.
    always_ff @(posedge i_clk) begin
        r_prevA  <= i_btn_A;
        r_prevB  <= i_btn_B;
        r_prevOp <= i_btn_OP;
    end

    assign w_edgeA  = i_btn_A  & ~r_prevA;
    assign w_edgeB  = i_btn_B  & ~r_prevB;
    assign w_edgeOp = i_btn_OP & ~r_prevOp;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_loadedNext = r_loaded;
        case (r_state)
            ST_LOAD: begin
                if (w_edgeA)  w_loadedNext[LD_A]  = 1'b1;
                if (w_edgeB)  w_loadedNext[LD_B]  = 1'b1;
                if (w_edgeOp) w_loadedNext[LD_OP] = 1'b1;
                if (w_loadedNext == 3'b111) w_nextState = ST_EXEC;
            end
            ST_EXEC: begin
                w_loadedNext = '0;
                w_nextState  = ST_LOAD;
            end
            default: begin
                w_loadedNext = '0;
                w_nextState  = ST_LOAD;
            end
        endcase
    end

    alu_core #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_core (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_aluResult),
        .o_carry  (w_aluCarry),
        .o_ovf    (w_aluOvf),
        .o_err    (w_aluErr)
    );

    // Edges arriving during EXEC are simply not captured.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_loaded <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_loaded <= w_loadedNext;
            r_valid  <= 1'b0;
            if (r_state == ST_LOAD) begin
                if (w_edgeA)  r_a  <= i_switches;
                if (w_edgeB)  r_b  <= i_switches;
                if (w_edgeOp) r_op <= i_switches[OP_W-1:0];
            end else begin
                r_result <= w_aluResult;
                r_carry  <= w_aluCarry;
                r_ovf    <= w_aluOvf;
                r_err    <= w_aluErr;
                r_zero   <= (w_aluResult == '0);
                r_valid  <= 1'b1;
            end
        end
    end

    assign o_result = r_result;
    assign o_valid  = r_valid;
    assign o_carry  = r_carry;
    assign o_zero   = r_zero;
    assign o_ovf    = r_ovf;
    assign o_err    = r_err;
    assign o_loaded = r_loaded;

endmodule

// File: tb/tb_alu_loader.sv
// Self-checking bench for alu_loader (DATA_W=8): directed cases with literal
// expectations, then random button/switch traffic checked against an arithmetic model.
module tb_alu_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw = 8'h00;
    logic       btnA = 1'b0;
    logic       btnB = 1'b0;
    logic       btnOp = 1'b0;
    logic [7:0] oResult;
    logic       oValid;
    logic       oCarry;
    logic       oZero;
    logic       oOvf;
    logic       oErr;
    logic [2:0] oLoaded;

    int totalCount = 0;
    int badCount = 0;

    int mA = 0;
    int mB = 0;
    int mOp = 0;
    int mLoaded = 0;
    int expResult = 0;
    int expCarry = 0;
    int expZero = 0;
    int expOvf = 0;
    int expErr = 0;
    int expValid = 0;
    bit resultDue = 1'b0;
    bit modelReady = 1'b0;
    bit [2:0] prevBtn = 3'b000;

    alu_loader #(
        .DATA_W (8),
        .OP_W   (6)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_switches (sw),
        .i_btn_A    (btnA),
        .i_btn_B    (btnB),
        .i_btn_OP   (btnOp),
        .o_result   (oResult),
        .o_valid    (oValid),
        .o_carry    (oCarry),
        .o_zero     (oZero),
        .o_ovf      (oOvf),
        .o_err      (oErr),
        .o_loaded   (oLoaded)
    );

    always #5 clk = ~clk;

    // Reference ALU in plain integer arithmetic on 8-bit values.
    task automatic refAlu(input int a, input int b, input int op,
                          output int res, output int carry, output int ovf, output int err);
        int sa;
        int sb;
        int s;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        res = 0;
        carry = 0;
        ovf = 0;
        err = 0;
        case (op)
            32: begin
                res = (a + b) % 256;
                carry = (a + b > 255) ? 1 : 0;
                s = sa + sb;
                ovf = (s > 127 || s < -128) ? 1 : 0;
            end
            34: begin
                res = (a - b + 256) % 256;
                carry = (a < b) ? 1 : 0;
                s = sa - sb;
                ovf = (s > 127 || s < -128) ? 1 : 0;
            end
            36: res = a & b;
            37: res = a | b;
            38: res = a ^ b;
            39: res = (~(a | b)) & 255;
            3:  res = (sa >>> (b % 8)) & 255;
            2:  res = a >> (b % 8);
            default: err = 1;
        endcase
    endtask

    task automatic modelStep();
        bit [2:0] btns;
        bit [2:0] edges;
        btns = {btnOp, btnB, btnA};
        if (reset) begin
            mA = 0;
            mB = 0;
            mOp = 0;
            mLoaded = 0;
            expResult = 0;
            expCarry = 0;
            expZero = 0;
            expOvf = 0;
            expErr = 0;
            expValid = 0;
            resultDue = 1'b0;
            prevBtn = btns;
            modelReady = 1'b1;
        end else begin
            edges = btns & ~prevBtn;
            prevBtn = btns;
            expValid = 0;
            if (resultDue) begin
                refAlu(mA, mB, mOp, expResult, expCarry, expOvf, expErr);
                expZero = (expResult == 0) ? 1 : 0;
                expValid = 1;
                mLoaded = 0;
                resultDue = 1'b0;
            end else begin
                if (edges[0]) begin mA = int'(sw); mLoaded = mLoaded | 1; end
                if (edges[1]) begin mB = int'(sw); mLoaded = mLoaded | 2; end
                if (edges[2]) begin mOp = int'(sw) & 63; mLoaded = mLoaded | 4; end
                if (mLoaded == 7) resultDue = 1'b1;
            end
        end
    endtask

    always @(posedge clk) modelStep();

    task automatic checkOutput(input string name, input int act, input int exp);
        totalCount++;
        if (act != exp) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        if (modelReady) begin
            checkOutput("model_result", int'(oResult), expResult);
            checkOutput("model_valid",  int'(oValid),  expValid);
            checkOutput("model_carry",  int'(oCarry),  expCarry);
            checkOutput("model_zero",   int'(oZero),   expZero);
            checkOutput("model_ovf",    int'(oOvf),    expOvf);
            checkOutput("model_err",    int'(oErr),    expErr);
            checkOutput("model_loaded", int'(oLoaded), mLoaded);
        end
    endtask

    // Every bench wait goes through here so the model comparison runs each cycle.
    task automatic tick();
        @(negedge clk);
        compareAll();
    endtask

    task automatic pulseBtn(input int which, input logic [7:0] val);
        tick();
        sw = val;
        case (which)
            0: btnA = 1'b1;
            1: btnB = 1'b1;
            default: btnOp = 1'b1;
        endcase
        tick();
        btnA = 1'b0;
        btnB = 1'b0;
        btnOp = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        pulseBtn(0, a);
        pulseBtn(1, b);
        pulseBtn(2, op);
    endtask

    initial begin
        logic [7:0] opList [8];
        opList = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkOutput("rst_result", int'(oResult), 0);
        checkOutput("rst_valid",  int'(oValid),  0);
        checkOutput("rst_loaded", int'(oLoaded), 0);

        applyStimulus(8'h04, 8'h08, 8'h27);
        checkOutput("nor_valid_early", int'(oValid), 0);
        tick();
        checkOutput("nor_result", int'(oResult), 8'hF3);
        checkOutput("nor_valid",  int'(oValid),  1);
        checkOutput("nor_loaded", int'(oLoaded), 0);
        tick();
        checkOutput("nor_valid_drop", int'(oValid), 0);
        checkOutput("nor_hold",       int'(oResult), 8'hF3);

        applyStimulus(8'hFF, 8'h01, 8'h20);
        tick();
        checkOutput("add_result", int'(oResult), 0);
        checkOutput("add_carry",  int'(oCarry),  1);
        checkOutput("add_zero",   int'(oZero),   1);
        checkOutput("add_ovf",    int'(oOvf),    0);

        applyStimulus(8'h80, 8'h01, 8'h22);
        tick();
        checkOutput("sub_result", int'(oResult), 8'h7F);
        checkOutput("sub_ovf",    int'(oOvf),    1);
        checkOutput("sub_carry",  int'(oCarry),  0);

        applyStimulus(8'h80, 8'h02, 8'h03);
        tick();
        checkOutput("sra_result", int'(oResult), 8'hE0);

        applyStimulus(8'h12, 8'h34, 8'h3F);
        tick();
        checkOutput("err_result", int'(oResult), 0);
        checkOutput("err_flag",   int'(oErr),    1);
        checkOutput("err_zero",   int'(oZero),   1);

        // Held A button: only the first switch value may be taken.
        tick();
        sw = 8'h11;
        btnA = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            sw = 8'($urandom_range(0, 255));
        end
        tick();
        btnA = 1'b0;
        tick();
        checkOutput("held_loaded", int'(oLoaded), 1);
        pulseBtn(1, 8'h01);
        pulseBtn(2, 8'h20);
        tick();
        checkOutput("held_result", int'(oResult), 8'h12);

        // Reset between captures discards A and B.
        pulseBtn(0, 8'h05);
        pulseBtn(1, 8'h06);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulseBtn(2, 8'h20);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mid_rst_valid", int'(oValid), 0);
        end
        checkOutput("mid_rst_loaded", int'(oLoaded), 3'b100);
        pulseBtn(0, 8'h01);
        pulseBtn(1, 8'h02);
        tick();
        checkOutput("mid_rst_result", int'(oResult), 3);

        // A button held through reset must not capture afterwards.
        tick();
        reset = 1'b1;
        tick();
        btnA = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        btnA = 1'b0;
        tick();
        checkOutput("hold_rst_loaded", int'(oLoaded), 0);

        tick();
        sw = 8'h20;
        btnA = 1'b1;
        btnB = 1'b1;
        btnOp = 1'b1;
        tick();
        btnA = 1'b0;
        btnB = 1'b0;
        btnOp = 1'b0;
        checkOutput("sim_valid_early", int'(oValid), 0);
        tick();
        checkOutput("sim_result", int'(oResult), 8'h40);
        checkOutput("sim_valid",  int'(oValid),  1);

        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 2) != 0)
                sw = opList[$urandom_range(0, 7)] | 8'($urandom_range(0, 3) << 6);
            else
                sw = 8'($urandom_range(0, 255));
            btnA  = ($urandom_range(0, 3) == 0);
            btnB  = ($urandom_range(0, 3) == 0);
            btnOp = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 149) == 0);
        end
        reset = 1'b0;
        btnA = 1'b0;
        btnB = 1'b0;
        btnOp = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/alu_loader.md
ALU_LOADER -- requirements
Module: alu_loader

Interface
REQ-001 Parameter DATA_W, default 8: operand/result width, legal range 6..32.
REQ-002 Parameter OP_W, default 6: opcode width; SHALL be less than or equal to DATA_W.
REQ-003 i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 i_reset  input  1  reset, synchronous and active-high.
REQ-005 i_switches  input  DATA_W  data source for operand and opcode capture.
REQ-006 i_btn_A, i_btn_B, i_btn_OP  input  1 each  level buttons that request capture of A, B and opcode.
REQ-007 o_result  output  DATA_W  registered ALU result.
REQ-008 o_valid  output  1  one-cycle pulse when o_result updates.
REQ-009 o_carry, o_zero, o_ovf, o_err  output  1 each  registered flags, updated together with o_result.
REQ-010 o_loaded  output  3  {op,B,A} capture-status bits.

Function
REQ-011 Each button SHALL be rising-edge detected against its own registered previous sample; a held button SHALL produce exactly one capture.
REQ-012 On an edge in state LOAD:
  - btn_A edge: A <= i_switches, and loaded[0] is set.
  - btn_B edge: B <= i_switches, and loaded[1] is set.
  - btn_OP edge: OP <= i_switches[OP_W-1:0], and loaded[2] is set.
REQ-013 Simultaneous edges SHALL all capture the same i_switches value in the same cycle.
REQ-014 Re-capturing an already-loaded operand SHALL overwrite it without other side effects.
REQ-015 The FSM SHALL have two states, LOAD and EXEC; LOAD moves to EXEC on the clock edge at which loaded becomes 3'b111.
REQ-016 In EXEC, one cycle:
  - o_result and the flags are registered and o_valid is 1 in the following cycle.
  - loaded is cleared to 0.
  - the FSM returns to LOAD.
  - Result latency is 1 cycle after the final capture edge.
REQ-017 Button edges occurring while in EXEC SHALL be dropped.
REQ-018 o_result and the flags SHALL hold their values until the next valid pulse.
REQ-019 Opcodes (OP_W=6):
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
  - 000011 SRA, 000010 SRL: A shifted by B[$clog2(DATA_W)-1:0].
REQ-020 ADD and SUB SHALL be computed at DATA_W+1 bits:
  - o_carry = bit DATA_W (the borrow-out for SUB).
  - o_ovf = signed overflow.
  - Both are 0 for all other ops.
REQ-021 o_zero SHALL be 1 when the result equals 0, for every op.
REQ-022 An undefined opcode SHALL give o_result=0, o_err=1, o_zero=1, o_carry=0, o_ovf=0; o_err SHALL be 0 for defined ops.

Reset
REQ-023 While i_reset is 1, the block SHALL set:
  - A, B, OP, o_result, all flags, o_valid and loaded to 0.
  - the FSM to LOAD.
  - each button's previous-sample register to the current button level.
REQ-024 A button held through reset SHALL therefore not capture after reset.
REQ-025 Reset SHALL take priority over captures and EXEC in the same cycle; an interrupted operation is discarded.

Structure
REQ-026 Opcode localparams, FSM state encoding and the loaded-bit indices SHALL live in shared package alu_pkg.
REQ-027 Arithmetic and logic SHALL be the combinational sub-module alu_core (parameter DATA_W; inputs A, B, OP; outputs result, carry, ovf, err).
REQ-028 Capture, edge detection, FSM and output registers SHALL reside in alu_loader.

Verification (DATA_W=8)
REQ-029 A=0x04, B=0x08, OP=100111 -> o_result=0xF3, o_valid pulses once, one cycle after the OP edge, and o_loaded returns to 0.
REQ-030 ADD with 0xFF and 0x01 -> o_result=0x00, o_carry=1, o_zero=1, o_ovf=0.
REQ-031 Two checks:
  - SUB 0x80-0x01 -> o_result=0x7F, o_ovf=1, o_carry=0.
  - SRA 0x80 by 2 -> o_result=0xE0.
REQ-032 OP=111111 -> o_result=0x00, o_err=1; btn_A held for 10 cycles -> only one capture, and switch changes while held are ignored.
REQ-033 Reset asserted after the A and B captures, then only OP loaded -> no o_valid, and o_loaded=3'b100.
REQ-034 All three edges in one cycle with switches=0x20 -> A=B=0x20, OP=100000 ADD, o_result=0x40, o_valid one cycle later.
